axi_read_interconnect: RTL
==========================

// Module: axi_read_interconnect
// PURPOSE
//  Two-master, one-slave AXI read interconnect. Sits between the AR/R master ports of two read master/slave
//  tiles and the AR/R slave port of the target tile. It arbitrates AR requests round-robin and widens the
//  1-bit master ARID to the 2-bit slave ARID as {master_idx, ARID}. It routes R beats back by RID[1].
// PARAMETERS
//  ADDR_W     32  ARADDR width (= `buswidth)
//  DATA_W     32  RDATA width (= `buswidth)
//  MAX_OUTST  4   per-master outstanding-burst limit (used only with READ_IC_OUTST_LIMIT_EN)
// PORTS
//  ACLK                    in   1       clock, all logic rising-edge
//  ARESET                  in   1       asynchronous reset, active-high
//  M0_ARID / M1_ARID       in   1       master tag
//  Mx_ARADDR               in   ADDR_W  read address, x=0,1
//  Mx_ARLEN/SIZE/BURST     in   4/2/2   burst attributes
//  Mx_ARLOCK/CACHE/PROT    in   2/4/3   burst attributes
//  Mx_ARVALID              in   1       request valid
//  Mx_ARREADY              out  1       request accepted
//  S_ARID                  out  2       {grant_idx, Mx_ARID}
//  S_ARADDR..S_ARPROT      out  as Mx   muxed payload of granted master
//  S_ARVALID               out  1       granted master's ARVALID
//  S_ARREADY               in   1       slave accept
//  S_RID                   in   2       [1]=destination master, [0]=tag
//  S_RDATA/RRESP/RLAST     in   DATA_W/2/1  read beat
//  S_RVALID                in   1       beat valid
//  S_RREADY                out  1       selected master's RREADY
//  Mx_RID                  out  1       S_RID[0]
//  Mx_RDATA/RRESP/RLAST    out  DATA_W/2/1  broadcast of S_R* payload
//  Mx_RVALID               out  1       S_RVALID & (S_RID[1]==x)
//  Mx_RREADY               in   1       master accept
// BEHAVIOUR
//  AR FSM, states IDLE, GRANT0, GRANT1; state register and last_grant are flops.
//  - IDLE: if exactly one master is eligible and its ARVALID is high, go to GRANTx.
//    If both are eligible with ARVALID high, grant the one != last_grant.
//  - GRANTx: S_ARVALID=Mx_ARVALID; S_AR* = Mx_AR*; Mx_ARREADY=S_ARREADY; the other ARREADY=0.
//  - GRANTx: on handshake (Mx_ARVALID&S_ARREADY), last_grant<=x and the FSM returns to IDLE.
//    Otherwise it holds GRANTx; the grant is never revoked while a request is pending.
//  - Latency: ARVALID rising in cycle N -> S_ARVALID in N+1. Peak rate is 1 AR per 2 cycles.
//  - IDLE: S_ARVALID=0, all ARREADY=0, S_AR* payload driven from M0 (don't-care).
//  R path is purely combinational, zero latency, with no buffering.
//  - Only the master addressed by S_RID[1] sees RVALID; S_RREADY = Mx_RREADY of that master.
//  - Master RREADY never affects the non-addressed master.
//  AR and R operate independently; an AR handshake and an R beat in the same cycle are both legal.
//  Reset (async, ARESET=1): state=IDLE, last_grant=1 (M0 wins first tie), counters=0.
//  - With S_ARVALID=0 and all ARREADY=0 immediately, mid-burst requests are discarded.
//  - Both neighbouring tiles are reset on the same signal.
//  Master eligibility: without the optional feature, a master is always eligible.
// CONFIGURATION
//  READ_IC_OUTST_LIMIT_EN defined: each master has a counter of width $clog2(MAX_OUTST+1).
//  - +1 on that master's AR handshake; -1 on an R handshake with RLAST routed to it.
//  - Both in the same cycle: unchanged.
//  - Master is ineligible while its count==MAX_OUTST; a current grant is never affected.
//  - Decrement at 0 saturates at 0 and fires a simulation $error.
//  READ_IC_OUTST_LIMIT_EN undefined: no counters; unlimited outstanding bursts.
// STRUCTURE
//  Shared package axi_read_pkg:
//  - ID widths (MID_W=1, SID_W=2) and AR payload width 49 (the 50-bit FIFO word minus the tag).
//  - FSM state encodings IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2.
//  One sub-module: read_rr_arbiter2 (req[1:0], eligible[1:0], last_grant -> grant_idx, grant_valid).
//  Muxing, ID widening and R routing stay in axi_read_interconnect.
// TESTING
//  1 M0 ARADDR=0x100,ARID=1,LEN=3, S_ARREADY=1 -> S_ARVALID next cycle, S_ARID=2'b01, M0_ARREADY 1 cycle.
//  2 M0,M1 both valid every cycle, S_ARREADY=1 -> grants alternate M0,M1,M0,M1; S_ARID[1]=0,1,0,1.
//  3 S_ARREADY low 5 cycles during GRANT1 -> S_AR* stable and M1 held. M0 requests wait; M0 wins after.
//  4 S_RID=2'b10,RDATA=0xDEADBEEF, M1_RREADY=0 -> M1_RVALID=1,M0_RVALID=0,S_RREADY=0; M1_RID=0.
//  5 LIMIT_EN, MAX_OUTST=2: M0 issues 3 ARs with no R -> third blocked; 1 RLAST to M0 -> third granted.
//  6 ARESET pulse mid-GRANT0 with ARVALID high -> S_ARVALID=0 same cycle; after release M0 wins first tie.

Source files
------------

// File: rtl/axi_read_pkg.sv
// Shared definitions for the two-master AXI read interconnect:
// ID widths, AR payload sizing, AR arbitration FSM states and the
// round-robin tie-break helper.
package axi_read_pkg;

  localparam int unsigned MID_W        = 1;
  localparam int unsigned SID_W        = 2;
  // LEN(4) + SIZE(2) + BURST(2) + LOCK(2) + CACHE(4) + PROT(3)
  localparam int unsigned AR_ATTR_W    = 17;
  // 32-bit address plus attributes: the 50-bit request FIFO word minus the tag
  localparam int unsigned AR_PAYLOAD_W = 49;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } ar_state_e;

  // Pick a winner among candidate requesters; on a tie the master that did
  // not win last time goes first.
  function automatic logic rr_pick(input logic [1:0] cand, input logic last_grant);
    if (cand == 2'b11) return ~last_grant;
    return cand[1];
  endfunction

endpackage

// File: rtl/axi_read_interconnect_arbiter.sv
// Two-way round-robin arbiter for AR requests. Purely combinational:
// a requester competes only while it is eligible.
module read_rr_arbiter2
  import axi_read_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_idx,
  output logic       grant_valid
);

  logic [1:0] cand;

  // Mask requests by eligibility and resolve ties round-robin
  always_comb begin
    cand        = req & eligible;
    grant_valid = |cand;
    grant_idx   = rr_pick(cand, last_grant);
  end

endmodule

// File: rtl/axi_read_interconnect.sv
// Two-master, one-slave AXI read interconnect.
// AR channel: round-robin arbitration through a three-state FSM; the 1-bit
// master ARID is widened to {grant_idx, ARID} on the slave side.
// R channel: combinational routing by S_RID[1], no buffering.
// Optional feature macro: READ_IC_OUTST_LIMIT_EN -- per-master count of
// outstanding bursts; a master at MAX_OUTST is not granted new requests.
module axi_read_interconnect
  import axi_read_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  // master 0 AR
  input  logic [MID_W-1:0]  M0_ARID,
  input  logic [ADDR_W-1:0] M0_ARADDR,
  input  logic [3:0]        M0_ARLEN,
  input  logic [1:0]        M0_ARSIZE,
  input  logic [1:0]        M0_ARBURST,
  input  logic [1:0]        M0_ARLOCK,
  input  logic [3:0]        M0_ARCACHE,
  input  logic [2:0]        M0_ARPROT,
  input  logic              M0_ARVALID,
  output logic              M0_ARREADY,
  // master 1 AR
  input  logic [MID_W-1:0]  M1_ARID,
  input  logic [ADDR_W-1:0] M1_ARADDR,
  input  logic [3:0]        M1_ARLEN,
  input  logic [1:0]        M1_ARSIZE,
  input  logic [1:0]        M1_ARBURST,
  input  logic [1:0]        M1_ARLOCK,
  input  logic [3:0]        M1_ARCACHE,
  input  logic [2:0]        M1_ARPROT,
  input  logic              M1_ARVALID,
  output logic              M1_ARREADY,
  // slave AR
  output logic [SID_W-1:0]  S_ARID,
  output logic [ADDR_W-1:0] S_ARADDR,
  output logic [3:0]        S_ARLEN,
  output logic [1:0]        S_ARSIZE,
  output logic [1:0]        S_ARBURST,
  output logic [1:0]        S_ARLOCK,
  output logic [3:0]        S_ARCACHE,
  output logic [2:0]        S_ARPROT,
  output logic              S_ARVALID,
  input  logic              S_ARREADY,
  // slave R
  input  logic [SID_W-1:0]  S_RID,
  input  logic [DATA_W-1:0] S_RDATA,
  input  logic [1:0]        S_RRESP,
  input  logic              S_RLAST,
  input  logic              S_RVALID,
  output logic              S_RREADY,
  // master 0 R
  output logic [MID_W-1:0]  M0_RID,
  output logic [DATA_W-1:0] M0_RDATA,
  output logic [1:0]        M0_RRESP,
  output logic              M0_RLAST,
  output logic              M0_RVALID,
  input  logic              M0_RREADY,
  // master 1 R
  output logic [MID_W-1:0]  M1_RID,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic [1:0]        M1_RRESP,
  output logic              M1_RLAST,
  output logic              M1_RVALID,
  input  logic              M1_RREADY
);

  localparam int unsigned PAY_W = ADDR_W + AR_ATTR_W;

  if (MAX_OUTST == 0) begin : g_bad_max_outst
    $error("axi_read_interconnect: MAX_OUTST must be at least 1");
  end

  ar_state_e        state_q, state_d;
  logic             last_grant_q;
  logic [1:0]       eligible;
  logic             arb_idx, arb_valid;
  logic [1:0]       ar_hs;
  logic             sel;
  logic [PAY_W-1:0] m0_pay, m1_pay, s_pay;

  assign m0_pay = {M0_ARADDR, M0_ARLEN, M0_ARSIZE, M0_ARBURST, M0_ARLOCK, M0_ARCACHE, M0_ARPROT};
  assign m1_pay = {M1_ARADDR, M1_ARLEN, M1_ARSIZE, M1_ARBURST, M1_ARLOCK, M1_ARCACHE, M1_ARPROT};
  assign {S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARLOCK, S_ARCACHE, S_ARPROT} = s_pay;

  assign ar_hs = {M1_ARVALID & M1_ARREADY, M0_ARVALID & M0_ARREADY};

  read_rr_arbiter2 u_arb (
    .req         ({M1_ARVALID, M0_ARVALID}),
    .eligible    (eligible),
    .last_grant  (last_grant_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

`ifdef READ_IC_OUTST_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  logic [CNT_W-1:0] outst_q [2];
  logic [1:0]       r_last_hs;

  assign r_last_hs[0] = S_RVALID & S_RREADY & S_RLAST & ~S_RID[SID_W-1];
  assign r_last_hs[1] = S_RVALID & S_RREADY & S_RLAST &  S_RID[SID_W-1];

  // Outstanding-burst counters: +1 per AR handshake, -1 per routed RLAST, saturating at 0
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      outst_q <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (ar_hs[i] && !r_last_hs[i])
          outst_q[i] <= outst_q[i] + CNT_W'(1);
        else if (!ar_hs[i] && r_last_hs[i] && outst_q[i] != '0)
          outst_q[i] <= outst_q[i] - CNT_W'(1);
      end
    end
  end

  // A master at its limit sits out arbitration; an active grant is unaffected
  always_comb begin
    for (int unsigned i = 0; i < 2; i++)
      eligible[i] = (outst_q[i] != CNT_W'(MAX_OUTST));
  end

`ifndef SYNTHESIS
  // An RLAST with nothing outstanding means the slave returned an unrequested burst
  always_ff @(posedge ACLK) begin
    for (int unsigned i = 0; i < 2; i++)
      if (!ARESET && r_last_hs[i] && !ar_hs[i] && outst_q[i] == '0)
        $error("axi_read_interconnect: outstanding count underflow on master %0d", i);
  end
`endif
`else
  assign eligible = '1;
`endif

  // State register and round-robin history
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (ar_hs[0])      last_grant_q <= 1'b0;
      else if (ar_hs[1]) last_grant_q <= 1'b1;
    end
  end

  // Next state: grant from IDLE, hold the grant until its handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = arb_idx ? GRANT1 : GRANT0;
      GRANT0:  if (ar_hs[0])  state_d = IDLE;
      GRANT1:  if (ar_hs[1])  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // AR outputs: connect the granted master to the slave; IDLE presents M0 with no valid
  always_comb begin
    sel        = 1'b0;
    S_ARVALID  = 1'b0;
    M0_ARREADY = 1'b0;
    M1_ARREADY = 1'b0;
    case (state_q)
      GRANT0: begin
        S_ARVALID  = M0_ARVALID;
        M0_ARREADY = S_ARREADY;
      end
      GRANT1: begin
        sel        = 1'b1;
        S_ARVALID  = M1_ARVALID;
        M1_ARREADY = S_ARREADY;
      end
      default: ;
    endcase
    s_pay  = sel ? m1_pay : m0_pay;
    S_ARID = {sel, (sel ? M1_ARID : M0_ARID)};
  end

  // R path: broadcast payload, steer valid/ready by the destination bit of RID
  always_comb begin
    M0_RID    = S_RID[MID_W-1:0];
    M1_RID    = S_RID[MID_W-1:0];
    M0_RDATA  = S_RDATA;
    M1_RDATA  = S_RDATA;
    M0_RRESP  = S_RRESP;
    M1_RRESP  = S_RRESP;
    M0_RLAST  = S_RLAST;
    M1_RLAST  = S_RLAST;
    M0_RVALID = S_RVALID & ~S_RID[SID_W-1];
    M1_RVALID = S_RVALID &  S_RID[SID_W-1];
    S_RREADY  = S_RID[SID_W-1] ? M1_RREADY : M0_RREADY;
  end

endmodule
